// File: rtl/rx_pingpong_pack_pkg.sv
// Shared types and constants for the ping-pong byte-to-word packer.
package rx_pingpong_pack_pkg;

    // Read-side FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2
    } rd_state_t;

    // Byte lane selectors, in arrival order
    localparam logic [1:0] LANE_B0 = 2'd0;  // word[31:24]
    localparam logic [1:0] LANE_B1 = 2'd1;  // word[23:16]
    localparam logic [1:0] LANE_B2 = 2'd2;  // word[15:8]
    localparam logic [1:0] LANE_B3 = 2'd3;  // word[7:0]

    // Place one byte in its big-endian lane; all other lanes are zero
    function automatic logic [31:0] lane_place(input logic [1:0] sel, input logic [7:0] b);
        logic [31:0] w;
        w = '0;
        case (sel)
            LANE_B0: w[31:24] = b;
            LANE_B1: w[23:16] = b;
            LANE_B2: w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rx_pingpong_pack_pp_dpram.sv
// Simple dual-port RAM, 2*DEPTH x 32, one write port and one registered read port.
module pp_dpram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          rdfifoclk,
    input  logic          wr_en,
    input  logic [AW:0]   wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW:0]   rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [0:2*DEPTH-1];

    // Write port plus one-cycle registered read
    always_ff @(posedge rdfifoclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_pingpong_pack.sv
// Packs a received byte stream into 32-bit big-endian words, buffers them in
// two ping-pong banks and streams each closed bank out with a valid/ready handshake.
module rx_pingpong_pack
    import rx_pingpong_pack_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic        rdfifoclk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic        word_last,
    input  logic        word_ready,
    output logic [1:0]  bank_full,
    output logic        overflow
);

    logic [1:0]    byte_sel;
    logic [31:0]   acc;
    logic [31:0]   cur_word;
    logic          commit;
    logic          wb;
    logic          rb;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   bank_len [2];
    logic          release_bank;
    logic          wr_block;
    logic          wr_ok;
    logic          close_bank;
    logic [1:0]    bank_full_nxt;
    logic [1:0]    ready_q;
    logic          rd_en;
    logic [AW:0]   rd_addr;
    logic [31:0]   rd_data;
    rd_state_t     state;
    rd_state_t     state_nxt;

    assign cur_word     = acc | lane_place(byte_sel, rx_data);
    assign commit       = rx_valid & ((byte_sel == LANE_B3) | rx_last);
    assign release_bank = (state == SHOW) & word_ready & word_last;
    // A bank being released on this edge may be written on the same edge
    assign wr_block     = bank_full[wb] & ~(release_bank & (rb == wb));
    assign wr_ok        = commit & ~wr_block;
    assign close_bank   = wr_ok & ((wr_ptr == AW'(DEPTH - 1)) | rx_last);

    pp_dpram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .rdfifoclk (rdfifoclk),
        .wr_en     (wr_ok),
        .wr_addr   ({wb, wr_ptr}),
        .wr_data   (cur_word),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    // Byte assembly: accumulate lanes, restart after every commit
    always_ff @(posedge rdfifoclk or negedge rst_n) begin
        if (!rst_n) begin
            byte_sel <= '0;
            acc      <= '0;
        end else if (rx_valid) begin
            if (commit) begin
                byte_sel <= '0;
                acc      <= '0;
            end else begin
                byte_sel <= byte_sel + 2'd1;
                acc      <= cur_word;
            end
        end
    end

    // Write pointer, bank toggle, stored lengths and sticky overflow
    always_ff @(posedge rdfifoclk or negedge rst_n) begin
        if (!rst_n) begin
            wb          <= 1'b0;
            wr_ptr      <= '0;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
            overflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                if (close_bank) begin
                    bank_len[wb] <= {1'b0, wr_ptr} + (AW+1)'(1);
                    wb           <= ~wb;
                    wr_ptr       <= '0;
                end else begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
            end
            if (commit & wr_block) begin
                overflow <= 1'b1;
            end
        end
    end

    // Bank flags: release clears first, then a closing commit may set the same bank again
    always_comb begin
        bank_full_nxt = bank_full;
        if (release_bank) begin
            bank_full_nxt[rb] = 1'b0;
        end
        if (close_bank) begin
            bank_full_nxt[wb] = 1'b1;
        end
    end

    // Bank flag register plus a one-cycle delayed copy that paces the read start
    always_ff @(posedge rdfifoclk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
            ready_q   <= '0;
        end else begin
            bank_full <= bank_full_nxt;
            ready_q   <= bank_full;
        end
    end

    // Read FSM next state and RAM read request
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = {rb, rd_ptr};
        case (state)
            IDLE: begin
                if (bank_full[rb] & ready_q[rb]) begin
                    state_nxt = FETCH;
                    rd_en     = 1'b1;
                end
            end
            FETCH: begin
                state_nxt = SHOW;
            end
            SHOW: begin
                if (word_ready) begin
                    if (word_last) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FETCH;
                        rd_en     = 1'b1;
                        rd_addr   = {rb, rd_ptr + AW'(1)};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read FSM state, read pointer, bank select and output word register
    always_ff @(posedge rdfifoclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rb         <= 1'b0;
            rd_ptr     <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FETCH) begin
                word_valid <= 1'b1;
                word_data  <= rd_data;
                word_last  <= ({1'b0, rd_ptr} == (bank_len[rb] - (AW+1)'(1)));
            end
            if ((state == SHOW) & word_ready) begin
                word_valid <= 1'b0;
                if (word_last) begin
                    rb     <= ~rb;
                    rd_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_pingpong_pack.sv
// Self-checking bench for rx_pingpong_pack: a byte-level model pushes expected
// words into a scoreboard, a monitor pops them on every output handshake.
module tb_rx_pingpong_pack;

    logic        rdfifoclk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_last;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic [1:0]  bank_full;
    logic        overflow;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          rx_cnt = 0;
    logic [1:0]  m_sel;
    logic [31:0] m_acc;
    int          m_ptr;

    always #5 rdfifoclk = ~rdfifoclk;

    rx_pingpong_pack #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .rdfifoclk  (rdfifoclk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_last    (rx_last),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .bank_full  (bank_full),
        .overflow   (overflow)
    );

    // Scoreboard consumer: every accepted output word must match the oldest expectation
    always @(negedge rdfifoclk) begin
        exp_t e;
        if (rst_n === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
            total++;
            rx_cnt++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word got=%h last=%b required=no word", word_data, word_last);
            end else begin
                e = sb.pop_front();
                if (word_data !== e.data || word_last !== e.last) begin
                    bad++;
                    $display("FAIL word got=%h last=%b required=%h last=%b",
                             word_data, word_last, e.data, e.last);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_sel = 2'd0;
        m_acc = 32'h0;
        m_ptr = 0;
        sb.delete();
    endtask

    // Drive one byte for one clock; model the packer and push the committed word if kept
    task automatic send_byte(input logic [7:0] d, input logic l, input logic keep);
        logic [31:0] w;
        exp_t        e;
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = l;
        @(posedge rdfifoclk);
        #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        w = m_acc;
        case (m_sel)
            2'd0:    w[31:24] = d;
            2'd1:    w[23:16] = d;
            2'd2:    w[15:8]  = d;
            default: w[7:0]   = d;
        endcase
        if (m_sel == 2'd3 || l) begin
            if (keep) begin
                e.data = w;
                e.last = (m_ptr == 15) || l;
                sb.push_back(e);
                m_ptr = e.last ? 0 : m_ptr + 1;
            end
            m_sel = 2'd0;
            m_acc = 32'h0;
        end else begin
            m_sel = m_sel + 2'd1;
            m_acc = w;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        word_ready = 1'b1;
        while ((sb.size() != 0 || word_valid === 1'b1) && n < 2000) begin
            @(posedge rdfifoclk);
            #1;
            n++;
        end
        repeat (8) @(posedge rdfifoclk);
        #1;
        total++;
        if (sb.size() != 0 || word_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain got left=%0d valid=%b required left=0 valid=0",
                     name, sb.size(), word_valid);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if (word_valid !== 1'b0) begin bad++; $display("FAIL %s_valid got=%b required=0", name, word_valid); end
        total++;
        if (word_data !== 32'h0) begin bad++; $display("FAIL %s_data got=%h required=00000000", name, word_data); end
        total++;
        if (word_last !== 1'b0) begin bad++; $display("FAIL %s_last got=%b required=0", name, word_last); end
        total++;
        if (bank_full !== 2'b00) begin bad++; $display("FAIL %s_bank_full got=%b required=00", name, bank_full); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL %s_overflow got=%b required=0", name, overflow); end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        rx_last    = 1'b0;
        word_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge rdfifoclk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge rdfifoclk);
        #1;
    endtask

    // 64 bytes into one bank, streamed out with ready held high
    task automatic test_stream();
        int start;
        start = rx_cnt;
        word_ready = 1'b1;
        for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0, 1'b1);
        drain("stream");
        total++;
        if (rx_cnt - start != 16) begin bad++; $display("FAIL stream_count got=%0d required=16", rx_cnt - start); end
        total++;
        if (bank_full !== 2'b00) begin bad++; $display("FAIL stream_bank_full got=%b required=00", bank_full); end
    endtask

    // Short frame with a zero-padded tail word, plus start latency from bank close
    task automatic test_partial_frame();
        word_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), (i == 5), 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge rdfifoclk);
            #1;
            total++;
            if (word_valid !== (k == 3)) begin
                bad++;
                $display("FAIL latency_edge%0d got=%b required=%b", k, word_valid, (k == 3));
            end
        end
        drain("partial");
    endtask

    // Stall the consumer for 10 cycles while a word is shown
    task automatic test_stall();
        logic [31:0] held;
        int          n;
        int          start;
        start = rx_cnt;
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), (i == 7), 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hD0 + 8'(i), (i == 3), 1'b1);
        n = 0;
        while (word_valid !== 1'b1 && n < 50) begin
            @(posedge rdfifoclk);
            #1;
            n++;
        end
        held = word_data;
        for (int k = 0; k < 10; k++) begin
            @(posedge rdfifoclk);
            #1;
            total++;
            if (word_valid !== 1'b1 || word_data !== held) begin
                bad++;
                $display("FAIL stall_hold got=%h valid=%b required=%h valid=1", word_data, word_valid, held);
            end
        end
        drain("stall");
        total++;
        if (rx_cnt - start != 3) begin bad++; $display("FAIL stall_count got=%0d required=3", rx_cnt - start); end
    endtask

    // Final handshake of bank0 coincides with a closing commit into bank0
    task automatic test_release_commit();
        int n;
        word_ready = 1'b0;
        for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b0, 1'b1);
        n = 0;
        while (!(word_valid === 1'b1 && word_last === 1'b1) && n < 500) begin
            word_ready = 1'b1;
            @(posedge rdfifoclk);
            #1;
            n++;
        end
        word_ready = 1'b0;
        total++;
        if (n >= 500) begin bad++; $display("FAIL relcommit_reach_last got=timeout required=last word shown"); end
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0, 1'b1);
        word_ready = 1'b1;
        send_byte(8'hE3, 1'b1, 1'b1);
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL relcommit_overflow got=%b required=0", overflow); end
        drain("relcommit");
        total++;
        if (overflow !== 1'b0 || bank_full !== 2'b00) begin
            bad++;
            $display("FAIL relcommit_end got ovf=%b full=%b required ovf=0 full=00", overflow, bank_full);
        end
    endtask

    // Both banks full, further words dropped and flagged
    task automatic test_overflow();
        int start;
        start = rx_cnt;
        word_ready = 1'b0;
        for (int i = 0; i < 192; i++) send_byte(8'(i), 1'b0, (i < 128));
        repeat (4) @(posedge rdfifoclk);
        #1;
        total++;
        if (bank_full !== 2'b11) begin bad++; $display("FAIL ovf_bank_full got=%b required=11", bank_full); end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b required=1", overflow); end
        drain("ovf");
        total++;
        if (rx_cnt - start != 32) begin bad++; $display("FAIL ovf_count got=%0d required=32", rx_cnt - start); end
        total++;
        if (bank_full !== 2'b00 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_end got full=%b ovf=%b required full=00 ovf=1", bank_full, overflow);
        end
    endtask

    // Reset in the middle of a frame, then a fresh single-word frame
    task automatic test_reset_mid();
        int start;
        word_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_idle_outputs("midreset");
        @(posedge rdfifoclk);
        #1;
        rst_n = 1'b1;
        model_reset();
        start = rx_cnt;
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        send_byte(8'h33, 1'b0, 1'b1);
        send_byte(8'h44, 1'b1, 1'b1);
        drain("midreset");
        total++;
        if (rx_cnt - start != 1) begin bad++; $display("FAIL midreset_count got=%0d required=1", rx_cnt - start); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_partial_frame();
        test_stall();
        test_release_commit();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
